compressed_encoder: RTL and testbench
=====================================

# compressed_encoder

RVC compressor and parcel packer, the inverse of the fetch-side compressed decoder. It accepts a stream of 32-bit RV32I instructions and re-encodes each one into its 16-bit C-extension form when a supported mapping exists. It then packs the resulting 16/32-bit parcels, little-endian, into a dense stream of 32-bit words. It sits in the code-image/self-test path, so its output can be replayed through instruction fetch and the compressed decoder.

## Interface
- `EN_COMPRESS`, default 1: when 0, every instruction is emitted as a 32-bit parcel and the counter stays 0.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: input instruction valid.
- `in_ready_o` out 1: input accepted when `in_valid_i && in_ready_o`.
- `instr_i` in 32: RV32I instruction.
- `flush_i` in 1: level request to emit any pending halfword.
- `flush_done_o` out 1: `flush_i` high and no halfword pending.
- `out_valid_o` out 1: output word valid.
- `out_ready_i` in 1: downstream accepts the word.
- `out_data_o` out 32: packed word; the earlier parcel is in [15:0].
- `pend_valid_o` out 1: a halfword is held awaiting a partner.
- `cnt_comp_o` out 16: number of instructions emitted as 16-bit; wraps.

## Operation
- Inputs with `instr_i[1:0]` != 2'b11 are not examined and are emitted unchanged as a 32-bit parcel.
- Compression rules are checked on field decode. The notation r' means x8..x15, encoded as r[2:0]. Register fields are rd=[11:7], rs1=[19:15], rs2=[24:20]. Any instruction that matches no rule stays 32-bit.
  - **addi** rd,rd,imm; rd≠0, imm≠0, imm∈[-32,31] → c.addi {000,imm[5],rd,imm[4:0],01}
  - **addi** rd,x0,imm; rd≠0, imm∈[-32,31] → c.li {010,imm[5],rd,imm[4:0],01}
  - **add** rd,x0,rs2; rd≠0, rs2≠0 → c.mv {100,0,rd,rs2,10}
  - **add** rd,rd,rs2; rd≠0, rs2≠0 → c.add {100,1,rd,rs2,10}
  - **sub/xor/or/and** rd',rd',rs2' → {100011,rd',ff,rs2',01}, where ff = 00/01/10/11 respectively
  - **lw** rd',off(rs1'); off[1:0]=0, off∈[0,124] → c.lw {010,off[5:3],rs1',off[2],off[6],rd',00}
  - **sw** rs2',off(rs1'); same offset rule → c.sw {110,off[5:3],rs1',off[2],off[6],rs2',00}
  - **jalr** x0,0(rs1); rs1≠0 → c.jr {100,0,rs1,00000,10}. **jalr** x1,0(rs1); rs1≠0 → c.jalr {100,1,rs1,00000,10}
  - **0x00100073** (ebreak) → 16'h9002
- Packing, applied on each accept. P is the pending halfword.
  - No P, 16-bit parcel: P=c16; no output.
  - No P, 32-bit parcel: output word = instr.
  - P held, 16-bit parcel: output {c16,P}; P cleared.
  - P held, 32-bit parcel: output {instr[15:0],P}; P=instr[31:16].
- Flush handling:
  - While `flush_i` is high, `in_ready_o`=0.
  - If P is held and the output slot is free, output {16'h0001,P} (c.nop pad) and clear P.
  - `flush_done_o` asserts combinationally once P is clear.
- `cnt_comp_o` increments by 1 on each accepted instruction that compresses.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_data_o`=0, `pend_valid_o`=0, `cnt_comp_o`=0.
  - `in_ready_o`=1.
  - `flush_done_o` follows `flush_i`.
- Reset asserted mid-operation discards P and any undelivered word, with no partial output.
- Output register: a word is produced in the cycle after the accept edge.
  - `out_valid_o`/`out_data_o` hold stable until `out_ready_i`.
  - `in_ready_o` = !flush_i && (!out_valid_o || out_ready_i), so full throughput is one instruction per cycle.
- Simultaneous output drain and new accept in the same cycle: the old word retires and the new word loads; no bubble.
- A 16-bit accept with no P holds nothing in the output slot; `out_valid_o` drops after drain if there is no new word.
- Flush pad word appears one cycle after the cycle in which the slot is free and P is held.

## Test plan
- **Two identical compressions pack into one word:** `addi x8,x8,5` (0x00540413) twice.
  - After the first accept: `pend_valid_o`=1 and no output.
  - One cycle after the second accept: `out_data_o`=0x04150415, and `cnt_comp_o`=2.
- **Compressed + 32-bit straddle, then flush:** `add x10,x0,x11` (0x00B00533), then `lui x1,0x12345` (0x123450B7).
  - Expected output 0x50B7852E, and P=0x1234.
  - Raise `flush_i`: output 0x00011234, then `flush_done_o`=1.
- **ebreak with the parameter disabled:** 0x00100073 sent twice.
  - `EN_COMPRESS`=1: output 0x90029002.
  - `EN_COMPRESS`=0: outputs 0x00100073 then 0x00100073, and `cnt_comp_o`=0.
- **lw offset boundary:** `lw x9,8(x10)` (0x00852483), then `lw x9,2(x10)` (0x00252483).
  - The first compresses to 0x4504; the second stays 32-bit.
  - Expected output 0x24834504, and P=0x0025.
- **Backpressure:** hold `out_ready_i`=0 for 5 cycles with a word valid.
  - `in_ready_o`=0 and `out_data_o` stays stable throughout.
  - Release: the word retires and the next accept follows in the same cycle.
- **Reset mid-operation:** assert `rst_ni`=0 with P held and a word valid.
  - All outputs take their reset values immediately.
  - After release, a 32-bit instruction is output unchanged.

Source files
------------

// File: rtl/compressed_encoder_if.sv
// Handshake bundle for the RVC compressor: instruction input side,
// flush control, and the packed 32-bit output stream.
interface compressed_encoder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        pend_valid_o;
  logic [15:0] cnt_comp_o;

  // Encoder side
  modport slave (
    input  in_valid_i, instr_i, flush_i, out_ready_i,
    output in_ready_o, flush_done_o, out_valid_o, out_data_o, pend_valid_o, cnt_comp_o
  );

  // Producer/consumer side
  modport master (
    output in_valid_i, instr_i, flush_i, out_ready_i,
    input  in_ready_o, flush_done_o, out_valid_o, out_data_o, pend_valid_o, cnt_comp_o
  );
endinterface

// File: rtl/compressed_encoder.sv
// RVC compressor and parcel packer: re-encodes RV32I instructions into
// 16-bit C forms where possible and packs parcels little-endian into words.
module compressed_encoder #(
  parameter bit EN_COMPRESS = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  compressed_encoder_if.slave bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_i, off_s;
  logic        rd_p, rs1_p, rs2_p, imm_small;

  assign instr     = bus.instr_i;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign rd        = instr[11:7];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign imm_i     = instr[31:20];
  assign off_s     = {instr[31:25], instr[11:7]};
  assign rd_p      = (rd[4:3] == 2'b01);
  assign rs1_p     = (rs1[4:3] == 2'b01);
  assign rs2_p     = (rs2[4:3] == 2'b01);
  assign imm_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

  logic        comp_ok;
  logic [15:0] comp_data;
  logic        alu_hit;
  logic [1:0]  alu_ff;

  // Decode the instruction fields and build the 16-bit encoding when a mapping exists
  always_comb begin
    comp_ok   = 1'b0;
    comp_data = 16'h0000;
    alu_hit   = 1'b0;
    alu_ff    = 2'b00;
    case ({funct7, funct3})
      {7'b0100000, 3'b000}: begin alu_hit = 1'b1; alu_ff = 2'b00; end
      {7'b0000000, 3'b100}: begin alu_hit = 1'b1; alu_ff = 2'b01; end
      {7'b0000000, 3'b110}: begin alu_hit = 1'b1; alu_ff = 2'b10; end
      {7'b0000000, 3'b111}: begin alu_hit = 1'b1; alu_ff = 2'b11; end
      default: ;
    endcase
    if (EN_COMPRESS && instr[1:0] == 2'b11) begin
      if (instr == 32'h0010_0073) begin
        comp_ok   = 1'b1;
        comp_data = 16'h9002;
      end else begin
        case (opcode)
          7'b0010011: begin
            if (funct3 == 3'b000 && rd != 5'd0 && imm_small) begin
              if (rs1 == rd && imm_i != 12'd0) begin
                comp_ok   = 1'b1;
                comp_data = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
              end else if (rs1 == 5'd0) begin
                comp_ok   = 1'b1;
                comp_data = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
              end
            end
          end
          7'b0110011: begin
            if (funct7 == 7'd0 && funct3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
              if (rs1 == 5'd0) begin
                comp_ok   = 1'b1;
                comp_data = {4'b1000, rd, rs2, 2'b10};
              end else if (rs1 == rd) begin
                comp_ok   = 1'b1;
                comp_data = {4'b1001, rd, rs2, 2'b10};
              end
            end else if (alu_hit && rd_p && rs2_p && rs1 == rd) begin
              comp_ok   = 1'b1;
              comp_data = {6'b100011, rd[2:0], alu_ff, rs2[2:0], 2'b01};
            end
          end
          7'b0000011: begin
            if (funct3 == 3'b010 && rd_p && rs1_p && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
              comp_ok   = 1'b1;
              comp_data = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            end
          end
          7'b0100011: begin
            if (funct3 == 3'b010 && rs2_p && rs1_p && off_s[11:7] == 5'd0 && off_s[1:0] == 2'b00) begin
              comp_ok   = 1'b1;
              comp_data = {3'b110, off_s[5:3], rs1[2:0], off_s[2], off_s[6], rs2[2:0], 2'b00};
            end
          end
          7'b1100111: begin
            if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0) begin
              if (rd == 5'd0) begin
                comp_ok   = 1'b1;
                comp_data = {4'b1000, rs1, 5'd0, 2'b10};
              end else if (rd == 5'd1) begin
                comp_ok   = 1'b1;
                comp_data = {4'b1001, rs1, 5'd0, 2'b10};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_q, pend_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        slot_free, in_ready, accept;

  assign slot_free = !out_valid_q || bus.out_ready_i;
  assign in_ready  = !bus.flush_i && slot_free;
  assign accept    = bus.in_valid_i && in_ready;

  // Pack accepted parcels against the pending halfword, or pad it out on flush
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    cnt_d        = cnt_q;
    if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (comp_ok) begin
        cnt_d = cnt_q + 16'd1;
        if (pend_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = {comp_data, pend_q};
          pend_valid_d = 1'b0;
        end else begin
          pend_valid_d = 1'b1;
          pend_d       = comp_data;
        end
      end else if (pend_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = {instr[15:0], pend_q};
        pend_d      = instr[31:16];
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = instr;
      end
    end else if (bus.flush_i && pend_valid_q && slot_free) begin
      out_valid_d  = 1'b1;
      out_data_d   = {16'h0001, pend_q};
      pend_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any pending halfword and undelivered word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_q       <= 16'h0000;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0000_0000;
      cnt_q        <= 16'h0000;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.flush_done_o = bus.flush_i && !pend_valid_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.pend_valid_o = pend_valid_q;
  assign bus.cnt_comp_o   = cnt_q;

endmodule

// File: tb/tb_compressed_encoder.sv
// Testbench for compressed_encoder: directed sequences, a vector table and
// randomized traffic checked against a halfword-queue reference model.
module tb_compressed_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  compressed_encoder_if ifc ();
  compressed_encoder_if ifn ();

  compressed_encoder #(.EN_COMPRESS(1'b1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc.slave)
  );

  compressed_encoder #(.EN_COMPRESS(1'b0)) dut_nc (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifn.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ok;
    logic [15:0] c;
  } cres_t;

  typedef struct {
    logic [31:0] instr;
    bit          is_c;
    logic [15:0] c16;
  } vec_t;

  vec_t vecs[20];

  logic [15:0] hq[$];
  logic [31:0] expw[$];
  logic [15:0] model_cnt = 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference compression from the instruction field rules, computed with integers
  function automatic cres_t refCompress(input logic [31:0] ins);
    int op, f3, f7, rd, rs1, rs2, imm_i, imm_s, ff;
    cres_t r;
    r.ok = 1'b0;
    r.c  = 16'h0000;
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    rd    = int'(ins[11:7]);
    rs1   = int'(ins[19:15]);
    rs2   = int'(ins[24:20]);
    imm_i = int'($signed(ins[31:20]));
    imm_s = int'($signed({ins[31:25], ins[11:7]}));
    if (ins[1:0] != 2'b11) return r;
    if (ins == 32'h0010_0073) begin
      r.ok = 1'b1; r.c = 16'h9002; return r;
    end
    if (op == 19 && f3 == 0 && rd != 0 && imm_i >= -32 && imm_i <= 31) begin
      if (rs1 == rd && imm_i != 0) begin
        r.ok = 1'b1;
        r.c  = 16'(((imm_i >> 5) & 1) << 12 | rd << 7 | (imm_i & 31) << 2 | 1);
      end else if (rs1 == 0) begin
        r.ok = 1'b1;
        r.c  = 16'(16'h4000 | ((imm_i >> 5) & 1) << 12 | rd << 7 | (imm_i & 31) << 2 | 1);
      end
    end else if (op == 51) begin
      if (f7 == 0 && f3 == 0 && rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd)) begin
        r.ok = 1'b1;
        r.c  = 16'((rs1 == 0 ? 32'h8002 : 32'h9002) | rd << 7 | rs2 << 2);
      end else if (rd >= 8 && rd <= 15 && rs2 >= 8 && rs2 <= 15 && rs1 == rd) begin
        ff = -1;
        if (f7 == 32 && f3 == 0) ff = 0;
        else if (f7 == 0 && f3 == 4) ff = 1;
        else if (f7 == 0 && f3 == 6) ff = 2;
        else if (f7 == 0 && f3 == 7) ff = 3;
        if (ff >= 0) begin
          r.ok = 1'b1;
          r.c  = 16'(32'h8C01 | (rd - 8) << 7 | ff << 5 | (rs2 - 8) << 2);
        end
      end
    end else if (op == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
                 imm_i >= 0 && imm_i <= 124 && imm_i % 4 == 0) begin
      r.ok = 1'b1;
      r.c  = 16'(32'h4000 | ((imm_i >> 3) & 7) << 10 | (rs1 - 8) << 7 |
                 ((imm_i >> 2) & 1) << 6 | ((imm_i >> 6) & 1) << 5 | (rd - 8) << 2);
    end else if (op == 35 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 &&
                 imm_s >= 0 && imm_s <= 124 && imm_s % 4 == 0) begin
      r.ok = 1'b1;
      r.c  = 16'(32'hC000 | ((imm_s >> 3) & 7) << 10 | (rs1 - 8) << 7 |
                 ((imm_s >> 2) & 1) << 6 | ((imm_s >> 6) & 1) << 5 | (rs2 - 8) << 2);
    end else if (op == 103 && f3 == 0 && imm_i == 0 && rs1 != 0 && (rd == 0 || rd == 1)) begin
      r.ok = 1'b1;
      r.c  = 16'((rd == 0 ? 32'h8002 : 32'h9002) | rs1 << 7);
    end
    return r;
  endfunction

  // Model reset: pending halfwords, undelivered words and the counter vanish
  always @(negedge rst_n) begin
    hq.delete();
    expw.delete();
    model_cnt = 16'h0000;
  end

  logic  m_valid, m_slot, m_acc, m_pad;
  cres_t m_r;

  // Model update on each clock edge from the handshakes seen before the edge
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_valid = (expw.size() > 0);
      m_slot  = !m_valid || ifc.out_ready_i;
      m_acc   = ifc.in_valid_i && !ifc.flush_i && m_slot;
      m_pad   = !m_acc && ifc.flush_i && (hq.size() == 1) && m_slot;
      if (m_valid && ifc.out_ready_i) void'(expw.pop_front());
      if (m_acc) begin
        m_r = refCompress(ifc.instr_i);
        if (m_r.ok) begin
          hq.push_back(m_r.c);
          model_cnt = model_cnt + 16'd1;
        end else begin
          hq.push_back(ifc.instr_i[15:0]);
          hq.push_back(ifc.instr_i[31:16]);
        end
      end
      if (m_pad) hq.push_back(16'h0001);
      while (hq.size() >= 2) begin
        expw.push_back({hq[1], hq[0]});
        void'(hq.pop_front());
        void'(hq.pop_front());
      end
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("out_valid", 32'(ifc.out_valid_o), 32'(expw.size() > 0));
      if (expw.size() > 0) checkOutput("out_data", ifc.out_data_o, expw[0]);
      checkOutput("pend_valid", 32'(ifc.pend_valid_o), 32'(hq.size() == 1));
      checkOutput("cnt_comp", 32'(ifc.cnt_comp_o), 32'(model_cnt));
      checkOutput("in_ready", 32'(ifc.in_ready_o),
                  32'(!ifc.flush_i && (expw.size() == 0 || ifc.out_ready_i)));
      checkOutput("flush_done", 32'(ifc.flush_done_o), 32'(ifc.flush_i && hq.size() == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [31:0] ins);
    bit acc;
    acc = 1'b0;
    ifc.in_valid_i = 1'b1;
    ifc.instr_i    = ins;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      acc = ifc.in_ready_o;
      @(posedge clk);
      #1;
    end
    ifc.in_valid_i = 1'b0;
    if (!acc) checkOutput("accept timeout", 32'(acc), 32'd1);
  endtask

  task automatic checkReset();
    checkOutput("rst out_valid", 32'(ifc.out_valid_o), 32'd0);
    checkOutput("rst out_data", ifc.out_data_o, 32'd0);
    checkOutput("rst pend_valid", 32'(ifc.pend_valid_o), 32'd0);
    checkOutput("rst cnt_comp", 32'(ifc.cnt_comp_o), 32'd0);
    checkOutput("rst in_ready", 32'(ifc.in_ready_o), 32'(!ifc.flush_i));
    checkOutput("rst flush_done", 32'(ifc.flush_done_o), 32'(ifc.flush_i));
  endtask

  task automatic doReset();
    ifc.in_valid_i  = 1'b0;
    ifc.flush_i     = 1'b0;
    ifc.out_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checkReset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'($urandom_range(0, 31));
      default: return 5'($urandom_range(8, 15));
    endcase
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rd  = pickReg();
    rs1 = ($urandom_range(0, 1) == 1) ? rd : pickReg();
    rs2 = pickReg();
    case ($urandom_range(0, 7))
      0: begin
        imm = 12'($urandom_range(0, 80)) - 12'd40;
        if ($urandom_range(0, 3) == 0) imm = 12'($urandom);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
      end
      1: begin
        f7 = 7'd0;
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       begin f3 = 3'b000; f7 = 7'b0100000; end
          2:       f3 = 3'b100;
          3:       f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
      end
      2: begin
        imm = 12'($urandom_range(0, 130));
        return {imm, rs1, 3'b010, rd, 7'b0000011};
      end
      3: begin
        imm = 12'($urandom_range(0, 130));
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      4: begin
        imm = ($urandom_range(0, 3) == 0) ? 12'd4 : 12'd0;
        case ($urandom_range(0, 2))
          0:       rd = 5'd0;
          1:       rd = 5'd1;
          default: rd = 5'd5;
        endcase
        return {imm, rs1, 3'b000, rd, 7'b1100111};
      end
      5:       return 32'h0010_0073;
      6:       return $urandom;
      default: return {20'($urandom), 5'($urandom_range(0, 31)), 7'b0110111};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit done;

    vecs[0]  = '{32'h0054_0413, 1'b1, 16'h0415};
    vecs[1]  = '{32'h0004_0413, 1'b0, 16'h0000};
    vecs[2]  = '{32'hFE00_0293, 1'b1, 16'h5281};
    vecs[3]  = '{32'h0202_8293, 1'b0, 16'h0000};
    vecs[4]  = '{32'h01F2_8293, 1'b1, 16'h02FD};
    vecs[5]  = '{32'h00B0_0533, 1'b1, 16'h852E};
    vecs[6]  = '{32'h00B5_0533, 1'b1, 16'h952E};
    vecs[7]  = '{32'h4094_0433, 1'b1, 16'h8C05};
    vecs[8]  = '{32'h00E7_F7B3, 1'b1, 16'h8FF9};
    vecs[9]  = '{32'h0104_4433, 1'b0, 16'h0000};
    vecs[10] = '{32'h0085_2483, 1'b1, 16'h4504};
    vecs[11] = '{32'h0025_2483, 1'b0, 16'h0000};
    vecs[12] = '{32'h07C5_2483, 1'b1, 16'h5D64};
    vecs[13] = '{32'h0805_2483, 1'b0, 16'h0000};
    vecs[14] = '{32'h0094_2223, 1'b1, 16'hC044};
    vecs[15] = '{32'h0000_8067, 1'b1, 16'h8082};
    vecs[16] = '{32'h0002_80E7, 1'b1, 16'h9282};
    vecs[17] = '{32'h0040_8067, 1'b0, 16'h0000};
    vecs[18] = '{32'h0010_0073, 1'b1, 16'h9002};
    vecs[19] = '{32'h1234_5670, 1'b0, 16'h0000};

    ifc.in_valid_i = 1'b0; ifc.instr_i = 32'h0; ifc.flush_i = 1'b0; ifc.out_ready_i = 1'b1;
    ifn.in_valid_i = 1'b0; ifn.instr_i = 32'h0; ifn.flush_i = 1'b0; ifn.out_ready_i = 1'b1;

    // Reset values, including flush_done following flush
    #2;
    checkReset();
    ifc.flush_i = 1'b1;
    #1;
    checkReset();
    ifc.flush_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] two identical compressions");
    applyStimulus(32'h0054_0413);
    checkOutput("t1 pend after first", 32'(ifc.pend_valid_o), 32'd1);
    checkOutput("t1 no output", 32'(ifc.out_valid_o), 32'd0);
    applyStimulus(32'h0054_0413);
    checkOutput("t1 out_valid", 32'(ifc.out_valid_o), 32'd1);
    checkOutput("t1 word", ifc.out_data_o, 32'h0415_0415);
    checkOutput("t1 cnt", 32'(ifc.cnt_comp_o), 32'd2);
    tick();

    $display("[TB] straddle then flush");
    doReset();
    applyStimulus(32'h00B0_0533);
    applyStimulus(32'h1234_50B7);
    checkOutput("t2 word", ifc.out_data_o, 32'h50B7_852E);
    checkOutput("t2 pend", 32'(ifc.pend_valid_o), 32'd1);
    ifc.flush_i = 1'b1;
    #1;
    checkOutput("t2 in_ready flush", 32'(ifc.in_ready_o), 32'd0);
    checkOutput("t2 flush_done early", 32'(ifc.flush_done_o), 32'd0);
    tick();
    checkOutput("t2 pad word", ifc.out_data_o, 32'h0001_1234);
    checkOutput("t2 pad valid", 32'(ifc.out_valid_o), 32'd1);
    checkOutput("t2 flush_done", 32'(ifc.flush_done_o), 32'd1);
    ifc.flush_i = 1'b0;
    tick();

    $display("[TB] ebreak with and without compression");
    doReset();
    ifc.in_valid_i = 1'b1; ifc.instr_i = 32'h0010_0073;
    ifn.in_valid_i = 1'b1; ifn.instr_i = 32'h0010_0073;
    #1;
    checkOutput("t3 nc in_ready", 32'(ifn.in_ready_o), 32'd1);
    tick();
    checkOutput("t3 nc word1", ifn.out_data_o, 32'h0010_0073);
    checkOutput("t3 nc valid1", 32'(ifn.out_valid_o), 32'd1);
    checkOutput("t3 c pend", 32'(ifc.pend_valid_o), 32'd1);
    checkOutput("t3 nc in_ready2", 32'(ifn.in_ready_o), 32'd1);
    tick();
    ifc.in_valid_i = 1'b0;
    ifn.in_valid_i = 1'b0;
    checkOutput("t3 nc word2", ifn.out_data_o, 32'h0010_0073);
    checkOutput("t3 nc valid2", 32'(ifn.out_valid_o), 32'd1);
    checkOutput("t3 nc cnt", 32'(ifn.cnt_comp_o), 32'd0);
    checkOutput("t3 c word", ifc.out_data_o, 32'h9002_9002);
    checkOutput("t3 c cnt", 32'(ifc.cnt_comp_o), 32'd2);
    tick();
    checkOutput("t3 nc drained", 32'(ifn.out_valid_o), 32'd0);

    $display("[TB] lw offset boundary");
    doReset();
    applyStimulus(32'h0085_2483);
    applyStimulus(32'h0025_2483);
    checkOutput("t4 word", ifc.out_data_o, 32'h2483_4504);
    checkOutput("t4 pend", 32'(ifc.pend_valid_o), 32'd1);
    ifc.flush_i = 1'b1;
    tick();
    checkOutput("t4 pad word", ifc.out_data_o, 32'h0001_0025);
    ifc.flush_i = 1'b0;
    tick();

    $display("[TB] backpressure");
    doReset();
    ifc.out_ready_i = 1'b0;
    applyStimulus(32'h1234_50B7);
    ifc.in_valid_i = 1'b1;
    ifc.instr_i    = 32'h0000_10B7;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t5 in_ready held", 32'(ifc.in_ready_o), 32'd0);
      checkOutput("t5 data stable", ifc.out_data_o, 32'h1234_50B7);
      checkOutput("t5 valid held", 32'(ifc.out_valid_o), 32'd1);
      tick();
    end
    ifc.out_ready_i = 1'b1;
    #1;
    checkOutput("t5 in_ready release", 32'(ifc.in_ready_o), 32'd1);
    tick();
    ifc.in_valid_i = 1'b0;
    checkOutput("t5 next word", ifc.out_data_o, 32'h0000_10B7);
    checkOutput("t5 next valid", 32'(ifc.out_valid_o), 32'd1);
    tick();

    $display("[TB] reset mid-operation");
    doReset();
    ifc.out_ready_i = 1'b0;
    applyStimulus(32'h0054_0413);
    applyStimulus(32'h1234_50B7);
    checkOutput("t6 word before", ifc.out_data_o, 32'h50B7_0415);
    checkOutput("t6 pend before", 32'(ifc.pend_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkReset();
    tick();
    rst_n = 1'b1;
    ifc.out_ready_i = 1'b1;
    tick();
    applyStimulus(32'h0000_10B7);
    checkOutput("t6 word after", ifc.out_data_o, 32'h0000_10B7);
    checkOutput("t6 pend after", 32'(ifc.pend_valid_o), 32'd0);
    tick();

    $display("[TB] vector table");
    doReset();
    for (int v = 0; v < 20; v++) begin
      applyStimulus(vecs[v].instr);
      if (vecs[v].is_c) begin
        checkOutput("vec pend", 32'(ifc.pend_valid_o), 32'd1);
        ifc.flush_i = 1'b1;
        tick();
        checkOutput("vec c16", ifc.out_data_o, {16'h0001, vecs[v].c16});
        ifc.flush_i = 1'b0;
      end else begin
        checkOutput("vec 32b word", ifc.out_data_o, vecs[v].instr);
        checkOutput("vec 32b pend", 32'(ifc.pend_valid_o), 32'd0);
      end
      tick();
    end

    $display("[TB] randomized traffic");
    doReset();
    for (int n = 0; n < 600; n++) begin
      ifc.in_valid_i  = ($urandom_range(0, 3) != 0);
      ifc.instr_i     = randInstr();
      ifc.out_ready_i = ($urandom_range(0, 3) != 0);
      ifc.flush_i     = ($urandom_range(0, 15) == 0);
      tick();
    end
    ifc.in_valid_i  = 1'b0;
    ifc.out_ready_i = 1'b1;
    ifc.flush_i     = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      done = ifc.flush_done_o && !ifc.out_valid_o;
    end
    checkOutput("drain complete", 32'(done), 32'd1);
    checkOutput("model empty", 32'(expw.size() + hq.size()), 32'd0);
    ifc.flush_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
